// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 codes, writeback source
// encodings, FSM states and the access-size decode used on both bus paths.
package mem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Writeback result mux select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  // Access size from funct3; any encoding that is not a legal load/store
  // size for the given direction falls back to a full word.
  function automatic mem_size_e f_mem_size(input logic [2:0] funct3,
                                           input logic       is_store);
    mem_size_e size;
    size = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_SB:   size = SZ_BYTE;
        F3_SH:   size = SZ_HALF;
        F3_SW:   size = SZ_WORD;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: size = SZ_BYTE;
        F3_LH, F3_LHU: size = SZ_HALF;
        F3_LW:         size = SZ_WORD;
        default:       size = SZ_WORD;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data bus: store byte-enables and replicated
// write data, misalignment detection, and load lane select + extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_acc_funct3,
  input  logic        i_acc_is_store,
  input  logic [1:0]  i_acc_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  mem_size_e   w_acc_size;
  mem_size_e   w_ld_size;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic        w_ld_unsigned;

  // Decode access sizes for the issuing access and for the completing load
  always_comb begin
    w_acc_size = f_mem_size(i_acc_funct3, i_acc_is_store);
    w_ld_size  = f_mem_size(i_ld_funct3, 1'b0);
  end

  // Store lane alignment and misalignment check of the issuing access
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0000_0000;
    o_misaligned = 1'b0;
    case (w_acc_size)
      SZ_BYTE: begin
        o_be         = 4'b0001 << i_acc_off;
        o_wdata      = {4{i_st_data[7:0]}};
        o_misaligned = 1'b0;
      end
      SZ_HALF: begin
        o_be         = 4'b0011 << i_acc_off;
        o_wdata      = {2{i_st_data[15:0]}};
        o_misaligned = i_acc_off[0];
      end
      SZ_WORD: begin
        o_be         = 4'b1111;
        o_wdata      = i_st_data;
        o_misaligned = (i_acc_off != 2'b00);
      end
      default: begin
        o_be         = 4'b1111;
        o_wdata      = i_st_data;
        o_misaligned = (i_acc_off != 2'b00);
      end
    endcase
  end

  // Load lane select and sign/zero extension (funct3[2] marks unsigned)
  always_comb begin
    w_ld_byte     = i_rdata[{i_ld_off, 3'b000} +: 8];
    w_ld_half     = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
    w_ld_unsigned = i_ld_funct3[2];
    case (w_ld_size)
      SZ_BYTE: begin
        if (w_ld_unsigned) begin
          o_ld_data = {24'h00_0000, w_ld_byte};
        end else begin
          o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
        end
      end
      SZ_HALF: begin
        if (w_ld_unsigned) begin
          o_ld_data = {16'h0000, w_ld_half};
        end else begin
          o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
        end
      end
      SZ_WORD: o_ld_data = i_rdata;
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: issues data-memory accesses over a
// req/ready handshake, stalls the front of the pipe during wait states and
// holds the MEM/WB register that feeds the writeback mux.
module memory_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_write_m_i,
  input  logic [1:0]            result_src_m_i,
  input  logic                  mem_write_m_i,
  input  logic [2:0]            funct3_m_i,
  input  logic [ADDR_WIDTH-1:0] alu_result_m_i,
  input  logic [DATA_WIDTH-1:0] write_data_m_i,
  input  logic [4:0]            rd_addr_m_i,
  input  logic [DATA_WIDTH-1:0] pc_plus_4_m_i,
  input  logic                  flush_m_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_ready_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_m_o,
  output logic                  misaligned_o,
  output logic                  reg_write_wb_o,
  output logic [1:0]            result_src_wb_o,
  output logic [DATA_WIDTH-1:0] read_data_wb_o,
  output logic [DATA_WIDTH-1:0] alu_result_wb_o,
  output logic [DATA_WIDTH-1:0] pc_plus_4_wb_o,
  output logic [4:0]            rd_addr_wb_o
);

  mem_state_e            r_state;
  logic                  r_misaligned;

  // Request registers: the access held on the bus across wait states
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_req_we;
  logic [3:0]            r_req_be;
  logic [DATA_WIDTH-1:0] r_req_wdata;
  logic [2:0]            r_req_funct3;
  logic [1:0]            r_req_off;
  logic [4:0]            r_req_rd;
  logic                  r_req_reg_write;
  logic [1:0]            r_req_result_src;
  logic [DATA_WIDTH-1:0] r_req_pc4;
  logic [DATA_WIDTH-1:0] r_req_alu;
  logic                  r_req_is_load;

  // MEM/WB register
  logic                  r_reg_write_wb;
  logic [1:0]            r_result_src_wb;
  logic [DATA_WIDTH-1:0] r_read_data_wb;
  logic [DATA_WIDTH-1:0] r_alu_wb;
  logic [DATA_WIDTH-1:0] r_pc4_wb;
  logic [4:0]            r_rd_wb;

  logic                  w_is_store;
  logic                  w_is_load;
  logic                  w_mem_op;
  logic                  w_misaligned;
  logic                  w_live_req;
  logic                  w_mis_op;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [2:0]            w_ld_funct3;
  logic [1:0]            w_ld_off;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  lsu_align u_lsu_align (
    .i_acc_funct3   (funct3_m_i),
    .i_acc_is_store (w_is_store),
    .i_acc_off      (alu_result_m_i[1:0]),
    .i_st_data      (write_data_m_i),
    .o_be           (w_be),
    .o_wdata        (w_wdata),
    .o_misaligned   (w_misaligned),
    .i_ld_funct3    (w_ld_funct3),
    .i_ld_off       (w_ld_off),
    .i_rdata        (dmem_rdata_i),
    .o_ld_data      (w_ld_data)
  );

  // Classify the live instruction and decide whether it may issue now
  always_comb begin
    w_is_store  = mem_write_m_i;
    w_is_load   = (result_src_m_i == RES_MEM) && !mem_write_m_i;
    w_mem_op    = w_is_store || w_is_load;
    w_word_addr = {alu_result_m_i[ADDR_WIDTH-1:2], 2'b00};
    w_live_req  = (r_state == MEM_IDLE) && w_mem_op && !flush_m_i && !w_misaligned && !rst_i;
    w_mis_op    = (r_state == MEM_IDLE) && w_mem_op && !flush_m_i && w_misaligned;
  end

  // Load path sees the latched access while waiting, the live one otherwise
  always_comb begin
    if (r_state == MEM_WAIT) begin
      w_ld_funct3 = r_req_funct3;
      w_ld_off    = r_req_off;
    end else begin
      w_ld_funct3 = funct3_m_i;
      w_ld_off    = alu_result_m_i[1:0];
    end
  end

  // Bus drive and stall: live request in IDLE, frozen request in WAIT
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = {ADDR_WIDTH{1'b0}};
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = {DATA_WIDTH{1'b0}};
    if (rst_i) begin
      dmem_req_o = 1'b0;
    end else if (r_state == MEM_WAIT) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = r_req_we;
      dmem_addr_o  = r_req_addr;
      dmem_be_o    = r_req_be;
      dmem_wdata_o = r_req_wdata;
    end else if (w_live_req) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = w_is_store;
      dmem_addr_o  = w_word_addr;
      dmem_be_o    = w_be;
      dmem_wdata_o = w_wdata;
    end else begin
      dmem_req_o = 1'b0;
    end
    stall_m_o = dmem_req_o && !dmem_ready_i;
  end

  // FSM, request latch and MEM/WB update; WB fields default to a bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= MEM_IDLE;
      r_misaligned     <= 1'b0;
      r_req_addr       <= {ADDR_WIDTH{1'b0}};
      r_req_we         <= 1'b0;
      r_req_be         <= 4'b0000;
      r_req_wdata      <= {DATA_WIDTH{1'b0}};
      r_req_funct3     <= 3'b000;
      r_req_off        <= 2'b00;
      r_req_rd         <= 5'd0;
      r_req_reg_write  <= 1'b0;
      r_req_result_src <= 2'b00;
      r_req_pc4        <= {DATA_WIDTH{1'b0}};
      r_req_alu        <= {DATA_WIDTH{1'b0}};
      r_req_is_load    <= 1'b0;
      r_reg_write_wb   <= 1'b0;
      r_result_src_wb  <= 2'b00;
      r_read_data_wb   <= {DATA_WIDTH{1'b0}};
      r_alu_wb         <= {DATA_WIDTH{1'b0}};
      r_pc4_wb         <= {DATA_WIDTH{1'b0}};
      r_rd_wb          <= 5'd0;
    end else begin
      r_misaligned    <= w_mis_op;
      r_reg_write_wb  <= 1'b0;
      r_result_src_wb <= 2'b00;
      r_read_data_wb  <= {DATA_WIDTH{1'b0}};
      r_alu_wb        <= {DATA_WIDTH{1'b0}};
      r_pc4_wb        <= {DATA_WIDTH{1'b0}};
      r_rd_wb         <= 5'd0;
      case (r_state)
        MEM_IDLE: begin
          if (flush_m_i) begin
            r_state <= MEM_IDLE;
          end else if (!w_mem_op || (!w_misaligned && dmem_ready_i)) begin
            // Non-memory op or zero-wait access retires straight to WB
            r_reg_write_wb  <= reg_write_m_i;
            r_result_src_wb <= result_src_m_i;
            r_read_data_wb  <= w_is_load ? w_ld_data : {DATA_WIDTH{1'b0}};
            r_alu_wb        <= DATA_WIDTH'(alu_result_m_i);
            r_pc4_wb        <= pc_plus_4_m_i;
            r_rd_wb         <= rd_addr_m_i;
            r_state         <= MEM_IDLE;
          end else if (!w_misaligned) begin
            // Memory not ready: freeze the access and wait
            r_req_addr       <= w_word_addr;
            r_req_we         <= w_is_store;
            r_req_be         <= w_be;
            r_req_wdata      <= w_wdata;
            r_req_funct3     <= funct3_m_i;
            r_req_off        <= alu_result_m_i[1:0];
            r_req_rd         <= rd_addr_m_i;
            r_req_reg_write  <= reg_write_m_i;
            r_req_result_src <= result_src_m_i;
            r_req_pc4        <= pc_plus_4_m_i;
            r_req_alu        <= DATA_WIDTH'(alu_result_m_i);
            r_req_is_load    <= w_is_load;
            r_state          <= MEM_WAIT;
          end else begin
            r_state <= MEM_IDLE;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_i) begin
            r_reg_write_wb  <= r_req_reg_write;
            r_result_src_wb <= r_req_result_src;
            r_read_data_wb  <= r_req_is_load ? w_ld_data : {DATA_WIDTH{1'b0}};
            r_alu_wb        <= r_req_alu;
            r_pc4_wb        <= r_req_pc4;
            r_rd_wb         <= r_req_rd;
            r_state         <= MEM_IDLE;
          end else begin
            r_state <= MEM_WAIT;
          end
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

  assign misaligned_o    = r_misaligned;
  assign reg_write_wb_o  = r_reg_write_wb;
  assign result_src_wb_o = r_result_src_wb;
  assign read_data_wb_o  = r_read_data_wb;
  assign alu_result_wb_o = r_alu_wb;
  assign pc_plus_4_wb_o  = r_pc4_wb;
  assign rd_addr_wb_o    = r_rd_wb;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits between the EX/MEM register and the writeback stage.
- Issues loads and stores to the data memory over a req/ready handshake that allows wait states.
- Aligns store data and byte-enables, and extends load data.
- Holds the MEM/WB pipeline register whose outputs feed the writeback result mux.
- Requests a pipeline stall while a memory access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath and memory word width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
reg_write_m_i  in  1  instruction writes rd
result_src_m_i  in  2  00 ALU, 01 load data, 10 PC+4
mem_write_m_i  in  1  store instruction
funct3_m_i  in  3  load/store size and sign (RV32I encoding)
alu_result_m_i  in  ADDR_WIDTH  effective address or ALU result
write_data_m_i  in  DATA_WIDTH  store data, from rs2
rd_addr_m_i  in  5  destination register
pc_plus_4_m_i  in  DATA_WIDTH  PC+4
flush_m_i  in  1  kill the instruction currently in MEM
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  DATA_WIDTH  lane-aligned store data
dmem_ready_i  in  1  request accepted/completed; rdata valid this cycle
dmem_rdata_i  in  DATA_WIDTH  read word
stall_m_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
misaligned_o  out  1  one-cycle pulse: misaligned access dropped
reg_write_wb_o  out  1  MEM/WB register outputs
result_src_wb_o  out  2
read_data_wb_o  out  DATA_WIDTH  extended load data
alu_result_wb_o  out  DATA_WIDTH
pc_plus_4_wb_o  out  DATA_WIDTH
rd_addr_wb_o  out  5

Behaviour:
- Memory op: mem_write_m_i=1 (store), or result_src_m_i=01 (load).
- Misaligned when:
  - LH/LHU/SH and addr[0]=1;
  - LW/SW and addr[1:0]!=0.
- Misaligned op: no request; misaligned_o pulses for 1 cycle; WB gets a bubble (reg_write_wb_o=0).
- FSM states:
  - IDLE:
    - Aligned op and no flush: dmem_req_o driven combinationally from the inputs.
    - ready=1 in the same cycle: access completes, no stall.
    - ready=0: latch addr/we/be/wdata/funct3/addr[1:0]/rd/reg_write/result_src/pc_plus_4/alu_result into request registers, assert stall_m_o, go to WAIT.
    - In the cycle the access is found not ready, stall_m_o is combinational (=req & ~ready).
  - WAIT:
    - dmem_req_o=1 with the latched fields, held stable.
    - stall_m_o=1 until the cycle ready=1.
    - On ready=1: stall_m_o=0 in that cycle; MEM/WB captures the latched instruction with the extended load data; return to IDLE.
- MEM/WB register update (every clock edge):
  - Completed op or non-memory op: load all WB fields.
  - Stalled cycle (ready=0), flushed op, or misaligned op: bubble, i.e. reg_write_wb_o=0 and other fields don't-care (driven 0).
- Latency:
  - MEM→WB is 1 cycle for ALU ops and zero-wait accesses.
  - Each wait cycle adds 1 cycle and one bubble in WB.
- Load extension:
  - Lane selected by addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Store alignment:
  - SB: be=0001<<addr[1:0], byte replicated ×4.
  - SH: be=0011<<addr[1:0], half replicated ×2.
  - SW: be=1111.
- Write responses are ignored except as completion.
- Flush:
  - In IDLE, flush_m_i suppresses the request and yields a bubble.
  - In WAIT, flush_m_i is ignored: the bus transaction cannot be aborted, and the result is still written.
  - The hazard unit never flushes MEM while stall_m_o=1.
- Reset:
  - state=IDLE; every output and the MEM/WB register are 0; dmem_req_o=0; stall_m_o=0; misaligned_o=0.
  - Reset mid-WAIT drops the request in the next cycle regardless of ready.
- Unknown funct3 on a memory op is treated as a word access.

Decomposition:
- Package mem_pkg:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW;
  - result_src encodings RES_ALU/RES_MEM/RES_PC4;
  - mem_state_e {MEM_IDLE, MEM_WAIT}.
- Combinational sub-module lsu_align:
  - store path: be/wdata generation;
  - load path: lane select and extension;
  - misalignment detect.
  - Instantiated once; the load path is fed from the latched or live funct3/offset per state.

Test Plan:
- ALU op, alu_result=0x1234, rd=5, reg_write=1 → next cycle alu_result_wb_o=0x1234, rd_addr_wb_o=5, no dmem_req_o, stall_m_o=0.
- LB addr 0x103, rdata=0x80FF_FF7F, ready same cycle → dmem_addr_o=0x100; read_data_wb_o=0xFFFF_FF80. LBU → 0x0000_0080.
- SH addr 0x22, data 0x0000_ABCD, ready same cycle → be=1100, wdata=0xABCD_ABCD, we=1.
- LW addr 0x40, ready after 3 cycles, rdata=0xDEAD_BEEF:
  - stall_m_o high 3 cycles; WB bubbles 3 cycles;
  - then read_data_wb_o=0xDEAD_BEEF, reg_write_wb_o=1.
- LW addr 0x42 → no request, misaligned_o single pulse, reg_write_wb_o=0.
- rst_i during WAIT → next cycle dmem_req_o=0, stall_m_o=0, all WB outputs 0, state IDLE.
